// File: rtl/irq_ctrl.sv
// Peripheral interrupt controller: edge-latched requests, mask, fixed priority, drain/vector/return.
// Optional IRQ_SYNC_EN adds a 2-flop synchronizer on irq_i ahead of edge detection.
module irq_ctrl #(
    parameter int unsigned         NUM_IRQ      = 4,
    parameter int unsigned         ADDR_W       = 32,
    parameter int unsigned         DRAIN_CYCLES = 3,
    parameter logic [ADDR_W-1:0]   VEC_BASE     = 'h0000_0100,
    localparam int unsigned        IdW          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               mask_we_i,
    input  logic [NUM_IRQ-1:0] mask_wdata_i,
    input  logic [ADDR_W-1:0]  ex_pc_i,
    input  logic               eret_i,
    output logic               intreq_o,
    output logic               redirect_o,
    output logic [ADDR_W-1:0]  redirect_pc_o,
    output logic [ADDR_W-1:0]  epc_o,
    output logic               in_isr_o,
    output logic [IdW-1:0]     irq_id_o,
    output logic [NUM_IRQ-1:0] mask_o,
    output logic [NUM_IRQ-1:0] pending_o
);

    localparam int unsigned CntW = $clog2(DRAIN_CYCLES) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StVector,
        StIsr,
        StReturn
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [NUM_IRQ-1:0]   mask_q, mask_d;
    logic [NUM_IRQ-1:0]   prev_q;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]    epc_q, epc_d;
    logic [IdW-1:0]       id_q, id_d;
    logic [NUM_IRQ-1:0]   irq_s;
    logic [NUM_IRQ-1:0]   req;
    logic [NUM_IRQ-1:0]   edges;
    logic [NUM_IRQ-1:0]   clr;
    logic [IdW-1:0]       winner;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_i;
`endif

    assign req   = pending_q & mask_q;
    assign edges = irq_s & ~prev_q;

    // Descending scan so the lowest requesting index is the last one written.
    always_comb begin
        winner = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                winner = IdW'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        epc_d   = epc_q;
        id_d    = id_q;
        clr     = '0;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StDrain;
                    epc_d   = ex_pc_i;
                    id_d    = winner;
                    cnt_d   = CntW'(DRAIN_CYCLES - 1);
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    state_d = StVector;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StVector: begin
                clr     = NUM_IRQ'(1) << id_q;
                state_d = StIsr;
            end
            StIsr: begin
                if (eret_i) begin
                    state_d = StReturn;
                end
            end
            StReturn: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // A new edge in the clearing cycle keeps the bit set.
    assign pending_d = (pending_q & ~clr) | edges;
    assign mask_d    = mask_we_i ? mask_wdata_i : mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= '0;
            mask_q    <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            epc_q     <= '0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            prev_q    <= irq_s;
            cnt_q     <= cnt_d;
            epc_q     <= epc_d;
            id_q      <= id_d;
        end
    end

    always_comb begin
        intreq_o      = 1'b0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        in_isr_o      = 1'b0;
        unique case (state_q)
            StDrain: intreq_o = 1'b1;
            StVector: begin
                intreq_o      = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = VEC_BASE + (ADDR_W'(id_q) << 4);
            end
            StIsr: in_isr_o = 1'b1;
            StReturn: begin
                redirect_o    = 1'b1;
                redirect_pc_o = epc_q;
            end
            default: ;
        endcase
    end

    assign epc_o     = epc_q;
    assign irq_id_o  = id_q;
    assign mask_o    = mask_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl with default parameters.
// Expected latencies shift by two cycles when IRQ_SYNC_EN is defined.
module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq_i;
    logic        mask_we_i;
    logic [3:0]  mask_wdata_i;
    logic [31:0] ex_pc_i;
    logic        eret_i;
    logic        intreq_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] epc_o;
    logic        in_isr_o;
    logic [1:0]  irq_id_o;
    logic [3:0]  mask_o;
    logic [3:0]  pending_o;

    int errors = 0;
    int checks = 0;

    irq_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .irq_i         (irq_i),
        .mask_we_i     (mask_we_i),
        .mask_wdata_i  (mask_wdata_i),
        .ex_pc_i       (ex_pc_i),
        .eret_i        (eret_i),
        .intreq_o      (intreq_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .epc_o         (epc_o),
        .in_isr_o      (in_isr_o),
        .irq_id_o      (irq_id_o),
        .mask_o        (mask_o),
        .pending_o     (pending_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_redirect(input string tag, input int maxc);
        int n = 0;
        while (!redirect_o && n < maxc) begin
            step();
            n++;
        end
        check({tag, " redirect seen"}, 32'(redirect_o), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " intreq"},   32'(intreq_o),   32'd0);
        check({tag, " redirect"}, 32'(redirect_o), 32'd0);
        check({tag, " rpc"},      redirect_pc_o,   32'd0);
        check({tag, " epc"},      epc_o,           32'd0);
        check({tag, " in_isr"},   32'(in_isr_o),   32'd0);
        check({tag, " irq_id"},   32'(irq_id_o),   32'd0);
        check({tag, " mask"},     32'(mask_o),     32'd0);
        check({tag, " pending"},  32'(pending_o),  32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        irq_i        = '0;
        mask_we_i    = 1'b0;
        mask_wdata_i = '0;
        ex_pc_i      = '0;
        eret_i       = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_all_zero("reset");

        mask_we_i    = 1'b1;
        mask_wdata_i = 4'b1111;
        step();
        mask_we_i = 1'b0;
        check("mask write", 32'(mask_o), 32'hf);

        // Single source 2, resume PC 0x40, eret in cycle 10.
        for (int c = 0; c <= 12; c++) begin
            irq_i   = 4'b0100;
            ex_pc_i = (c >= 1) ? 32'h40 : 32'h0;
            eret_i  = (c == 10);
            check($sformatf("s1 intreq c%0d", c), 32'(intreq_o),
                  32'(c >= 2 + L && c <= 5 + L));
            check($sformatf("s1 redirect c%0d", c), 32'(redirect_o),
                  32'(c == 5 + L || c == 11));
            if (c == 5 + L) check("s1 vector pc", redirect_pc_o, 32'h120);
            if (c == 11)    check("s1 return pc", redirect_pc_o, 32'h40);
            check($sformatf("s1 in_isr c%0d", c), 32'(in_isr_o),
                  32'(c >= 6 + L && c <= 10));
            check($sformatf("s1 pending2 c%0d", c), 32'(pending_o[2]),
                  32'(c >= 1 + L && c <= 5 + L));
            step();
        end
        eret_i = 1'b0;
        check("s1 epc held", epc_o, 32'h40);
        check("s1 id held", 32'(irq_id_o), 32'd2);
        irq_i = '0;
        step();
        step();

        // Sources 1 and 3 together; mask source 1 off mid-drain without aborting it.
        ex_pc_i = 32'h200;
        irq_i   = 4'b1010;
        repeat (2 + L) step();
        check("s3 drain1", 32'(intreq_o), 32'd1);
        mask_we_i    = 1'b1;
        mask_wdata_i = 4'b1000;
        step();
        mask_we_i = 1'b0;
        check("s3 mask mid-drain", 32'(mask_o), 32'h8);
        wait_redirect("s3 v1", 10);
        check("s3 v1 pc", redirect_pc_o, 32'h110);
        check("s3 v1 id", 32'(irq_id_o), 32'd1);
        step();
        check("s3 isr1", 32'(in_isr_o), 32'd1);
        check("s3 pending after v1", 32'(pending_o), 32'h8);
        eret_i = 1'b1;
        step();
        eret_i = 1'b0;
        check("s3 ret1", 32'(redirect_o), 32'd1);
        check("s3 ret1 pc", redirect_pc_o, 32'h200);
        step();
        check("s3 idle", 32'(intreq_o), 32'd0);
        step();
        check("s3 drain3", 32'(intreq_o), 32'd1);
        wait_redirect("s3 v3", 10);
        check("s3 v3 pc", redirect_pc_o, 32'h130);
        check("s3 v3 id", 32'(irq_id_o), 32'd3);
        step();
        eret_i = 1'b1;
        step();
        eret_i = 1'b0;
        step();
        check("s3 done pending", 32'(pending_o), 32'h0);
        check("s3 done in_isr", 32'(in_isr_o), 32'd0);
        check("s3 done redirect", 32'(redirect_o), 32'd0);
        eret_i = 1'b1;
        step();
        eret_i = 1'b0;
        check("eret idle redirect", 32'(redirect_o), 32'd0);
        check("eret idle intreq", 32'(intreq_o), 32'd0);
        irq_i = '0;
        step();

        // Masked pending source 0, later unmasked; then set-vs-clear and reset in drain.
        mask_we_i    = 1'b1;
        mask_wdata_i = 4'b0000;
        step();
        mask_we_i = 1'b0;
        irq_i     = 4'b0001;
        repeat (3 + L) step();
        check("s4 masked pending", 32'(pending_o), 32'h1);
        check("s4 masked intreq", 32'(intreq_o), 32'd0);
        mask_we_i    = 1'b1;
        mask_wdata_i = 4'b0001;
        step();
        mask_we_i = 1'b0;
        check("s4 mask effect", 32'(mask_o), 32'h1);
        check("s4 still idle", 32'(intreq_o), 32'd0);
        step();
        check("s4 drain", 32'(intreq_o), 32'd1);
        irq_i = '0;
        wait_redirect("s4 v0", 10);
        check("s4 v0 pc", redirect_pc_o, 32'h100);
        irq_i = 4'b0001;
        repeat (3) step();
        check("s4 in_isr", 32'(in_isr_o), 32'd1);
        check("s4 set wins", 32'(pending_o), 32'h1);
        eret_i = 1'b1;
        step();
        eret_i = 1'b0;
        step();
        step();
        check("s4 redo drain", 32'(intreq_o), 32'd1);
        irq_i = '0;
        rst   = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("s4 reset in drain");
        repeat (5) begin
            step();
            check("s4 post-reset redirect", 32'(redirect_o), 32'd0);
            check("s4 post-reset intreq", 32'(intreq_o), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
